// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO management master.
// Frame body after the preamble, MSB first:
//   ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16) = 32 bits.
package mdio_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_IDLE_BIT,
    S_DONE
  } mdio_state_t;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  // Last-bit counter values for the fixed-length frame sections.
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  // One management request as seen on the request port.
  typedef struct packed {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  reg_addr;
    logic [15:0] wdata;
  } mdio_req_t;

  // Builds the 32-bit post-preamble frame. For reads, the turnaround and
  // data positions hold ones: the pin is released there, and keeping
  // mdio_o high matches the idle level of the line.
  function automatic logic [31:0] build_frame(input mdio_req_t r);
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] data;
    op   = r.write ? MDIO_OP_WR : MDIO_OP_RD;
    ta   = r.write ? MDIO_TA_WR : 2'b11;
    data = r.write ? r.wdata : 16'hFFFF;
    return {MDIO_ST, op, r.phy, r.reg_addr, ta, data};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: a down-counter from CLK_DIV-1 whose terminal count toggles
// mdc. o_rise / o_fall are combinational and high during the cycle whose
// closing clock edge produces the mdc edge, so a consumer's registers update
// on the very edge mdc changes. mdc is held low and the counter at its
// reload value while i_run is low.
module mdio_clk_gen
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic i_sys_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic mdc,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          mdc_reg;
  logic          tc;

  assign tc     = i_run && (cnt_reg == '0);
  assign o_rise = tc && !mdc_reg;
  assign o_fall = tc && mdc_reg;
  assign mdc    = mdc_reg;

  // Divider: reload and hold while stopped, toggle mdc on terminal count.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset || !i_run) begin
      cnt_reg <= RELOAD;
      mdc_reg <= 1'b0;
    end else if (tc) begin
      cnt_reg <= RELOAD;
      mdc_reg <= ~mdc_reg;
    end else begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO management master. Runs one read or write frame per
// accepted request and reports completion with a single-cycle pulse.
// The top level owns the tristate: mdio = mdio_oe ? mdio_o : 1'bz.
// Optional feature macro: MDIO_PREAMBLE_SUPPRESS_EN adds i_req_no_pre,
// which skips the preamble for that request.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [4:0]  i_req_phy,
  input  logic [4:0]  i_req_reg,
  input  logic [15:0] i_req_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        i_req_no_pre,
`endif
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST = 6'(PRE_LEN - 1);

  mdio_state_t state_reg;
  logic [5:0]  bit_cnt_reg;
  logic [31:0] sh_reg;
  logic        write_reg;
  logic        mdio_o_reg;
  logic        mdio_oe_reg;
  logic        rsp_valid_reg;
  logic [15:0] rdata_reg;
  logic        err_reg;
  logic [15:0] rd_sh_reg;
  logic        ta_err_reg;

  logic        run;
  logic        rise;
  logic        fall;
  logic        skip_pre;
  mdio_req_t   req_in;

  assign req_in = '{write: i_req_write, phy: i_req_phy,
                    reg_addr: i_req_reg, wdata: i_req_wdata};

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign skip_pre = (PRE_LEN == 0) || i_req_no_pre;
`else
  assign skip_pre = (PRE_LEN == 0);
`endif

  // The divider runs for the whole frame and is parked in IDLE.
  assign run = (state_reg != S_IDLE);

  mdio_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_sys_clk (i_sys_clk),
    .i_reset   (i_reset),
    .i_run     (run),
    .mdc       (mdc),
    .o_rise    (rise),
    .o_fall    (fall)
  );

  assign o_req_ready = (state_reg == S_IDLE);
  assign o_busy      = (state_reg != S_IDLE);
  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_rdata = rdata_reg;
  assign o_rsp_err   = err_reg;
  assign mdio_o      = mdio_o_reg;
  assign mdio_oe     = mdio_oe_reg;

  // Frame sequencer: new bits are presented on the edge mdc falls (or the
  // edge after accept for bit 0); read bits are sampled on the edge mdc rises.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      sh_reg        <= '0;
      write_reg     <= 1'b0;
      mdio_o_reg    <= 1'b1;
      mdio_oe_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      rd_sh_reg     <= '0;
      ta_err_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          mdio_o_reg  <= 1'b1;
          mdio_oe_reg <= 1'b0;
          if (i_req_valid) begin
            write_reg   <= i_req_write;
            sh_reg      <= build_frame(req_in);
            rd_sh_reg   <= '0;
            ta_err_reg  <= 1'b0;
            mdio_oe_reg <= 1'b1;
            if (skip_pre) begin
              state_reg   <= S_HDR;
              bit_cnt_reg <= HDR_LAST;
              mdio_o_reg  <= MDIO_ST[1];
            end else begin
              state_reg   <= S_PRE;
              bit_cnt_reg <= PRE_LAST;
              mdio_o_reg  <= 1'b1;
            end
          end
        end

        S_PRE: begin
          if (fall) begin
            if (bit_cnt_reg == '0) begin
              state_reg   <= S_HDR;
              bit_cnt_reg <= HDR_LAST;
              mdio_o_reg  <= sh_reg[31];
            end else begin
              bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end
          end
        end

        S_HDR: begin
          if (fall) begin
            sh_reg     <= {sh_reg[30:0], 1'b1};
            mdio_o_reg <= sh_reg[30];
            if (bit_cnt_reg == '0) begin
              // Reads release the pin for both turnaround bits.
              state_reg   <= S_TA;
              bit_cnt_reg <= TA_LAST;
              mdio_oe_reg <= write_reg;
            end else begin
              bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end
          end
        end

        S_TA: begin
          // A present PHY pulls the second turnaround bit low.
          if (rise && (bit_cnt_reg == '0) && !write_reg) begin
            ta_err_reg <= mdio_i;
          end
          if (fall) begin
            sh_reg     <= {sh_reg[30:0], 1'b1};
            mdio_o_reg <= sh_reg[30];
            if (bit_cnt_reg == '0) begin
              state_reg   <= S_DATA;
              bit_cnt_reg <= DATA_LAST;
            end else begin
              bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end
          end
        end

        S_DATA: begin
          if (rise && !write_reg) begin
            rd_sh_reg <= {rd_sh_reg[14:0], mdio_i};
          end
          if (fall) begin
            if (bit_cnt_reg == '0) begin
              state_reg   <= S_IDLE_BIT;
              bit_cnt_reg <= '0;
              mdio_oe_reg <= 1'b0;
              mdio_o_reg  <= 1'b1;
            end else begin
              sh_reg      <= {sh_reg[30:0], 1'b1};
              mdio_o_reg  <= sh_reg[30];
              bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end
          end
        end

        S_IDLE_BIT: begin
          if (fall) begin
            state_reg     <= S_DONE;
            rsp_valid_reg <= 1'b1;
            rdata_reg     <= write_reg ? 16'h0000 : rd_sh_reg;
            err_reg       <= write_reg ? 1'b0 : ta_err_reg;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master with CLK_DIV=4, PRE_LEN=32.
// Build with MDIO_PREAMBLE_SUPPRESS_EN to also exercise preamble suppression.
module tb_mdio_master;

  localparam int D   = 4;
  localparam int PRE = 32;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [4:0]  i_req_phy = '0;
  logic [4:0]  i_req_reg = '0;
  logic [15:0] i_req_wdata = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic        i_req_no_pre = 1'b0;
`endif
  logic        o_rsp_valid;
  logic [15:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(D), .PRE_LEN(PRE)) dut (
    .i_sys_clk   (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_write (i_req_write),
    .i_req_phy   (i_req_phy),
    .i_req_reg   (i_req_reg),
    .i_req_wdata (i_req_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .i_req_no_pre(i_req_no_pre),
`endif
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy),
    .mdc         (mdc),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .mdio_i      (mdio_i)
  );

  typedef struct {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic        phy_on;
    logic [15:0] phy_data;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // PHY model and line monitor state.
  int          tb_pre_n = PRE;
  logic        phy_on = 1'b0;
  logic [15:0] phy_data = '0;
  logic        phy_drive;
  logic        phy_val;
  int          phy_idx = 0;
  logic        mdc_prev = 1'b0;
  logic        contention = 1'b0;
  logic        cap_o  [0:127];
  logic        cap_oe [0:127];
  int          cap_n = 0;

  // PHY drives TA bit 2 low and then 16 data bits, MSB first.
  always_comb begin
    phy_drive = 1'b0;
    phy_val   = 1'b1;
    if (phy_on) begin
      if (phy_idx == tb_pre_n + 15) begin
        phy_drive = 1'b1;
        phy_val   = 1'b0;
      end else if (phy_idx >= tb_pre_n + 16 && phy_idx <= tb_pre_n + 31) begin
        phy_drive = 1'b1;
        phy_val   = phy_data[15 - (phy_idx - tb_pre_n - 16)];
      end
    end
  end

  // Bus with pull-up.
  assign mdio_i = mdio_oe ? mdio_o : (phy_drive ? phy_val : 1'b1);

  // Count mdc falls per frame, capture the driven line on each mdc rise.
  always @(posedge clk) begin
    mdc_prev <= mdc;
    if (o_req_ready) begin
      phy_idx    <= 0;
      cap_n      <= 0;
      contention <= 1'b0;
    end else begin
      if (mdc_prev && !mdc) phy_idx <= phy_idx + 1;
      if (!mdc_prev && mdc && cap_n < 128) begin
        cap_o[cap_n]  <= mdio_o;
        cap_oe[cap_n] <= mdio_oe;
        cap_n         <= cap_n + 1;
      end
      if (mdio_oe && phy_drive) contention <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int pre_n, input int i);
    logic [31:0] body;
    body = {2'b01, (v.write ? 2'b01 : 2'b10), v.phy, v.rg,
            (v.write ? 2'b10 : 2'b00), (v.write ? v.wdata : 16'h0000)};
    if (i < pre_n) return 1'b1;
    return body[31 - (i - pre_n)];
  endfunction

  function automatic logic exp_oe(input vec_t v, input int pre_n, input int i);
    if (i < pre_n + 14) return 1'b1;
    if (i < pre_n + 32) return v.write;
    return 1'b0;
  endfunction

  task automatic start_req(input vec_t v, input bit no_pre);
    i_req_write = v.write;
    i_req_phy   = v.phy;
    i_req_reg   = v.rg;
    i_req_wdata = v.wdata;
    phy_on      = v.phy_on;
    phy_data    = v.phy_data;
    tb_pre_n    = no_pre ? 0 : PRE;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    i_req_no_pre = no_pre;
`endif
    i_req_valid = 1'b1;
  endtask

  // Returns right after (#1) the edge that registered the accept.
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      bit rdy = o_req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    check({name, "_accept"}, 32'(ok), 32'd1);
  endtask

  // Counts edges from the accept edge until o_rsp_valid is seen.
  task automatic wait_rsp(output int cyc, output int first_rise, output int viol);
    cyc = 0; first_rise = -1; viol = 0;
    for (int n = 0; n < 2000; n++) begin
      if (o_rsp_valid) break;
      if (!o_busy || o_req_ready) viol++;
      @(posedge clk);
      #1;
      cyc++;
      if (mdc && first_rise < 0) first_rise = cyc;
    end
    if (!o_busy || o_req_ready) viol++;
  endtask

  task automatic check_frame(input string name, input vec_t v, input int pre_n);
    int nbits = pre_n + 33;
    int bad_o = 0;
    int bad_oe = 0;
    check({name, "_bitcount"}, 32'(cap_n), 32'(nbits));
    for (int i = 0; i < nbits && i < cap_n; i++) begin
      if (cap_oe[i] !== exp_oe(v, pre_n, i)) bad_oe++;
      if (exp_oe(v, pre_n, i) && cap_o[i] !== exp_bit(v, pre_n, i)) bad_o++;
    end
    check({name, "_bits_wrong"}, 32'(bad_o), 32'd0);
    check({name, "_oe_wrong"}, 32'(bad_oe), 32'd0);
    check({name, "_contention"}, 32'(contention), 32'd0);
  endtask

  // Response timing and content after accept; assumes just past accept edge.
  task automatic finish_txn(input int id, input string name, input vec_t v, input int pre_n);
    int cyc, fr, viol;
    wait_rsp(cyc, fr, viol);
    check({name, "_rsp_seen"}, 32'(o_rsp_valid), 32'd1);
    // Valid lands (F+1)*2*D edges after the accepting edge.
    check({name, "_latency"}, 32'(cyc), 32'((pre_n + 33) * 2 * D));
    check({name, "_first_rise"}, 32'(fr), 32'(D));
    check({name, "_busy_ready"}, 32'(viol), 32'd0);
    check({name, "_rdata"}, 32'(o_rsp_rdata), 32'(v.exp_rdata));
    check({name, "_err"}, 32'(o_rsp_err), 32'(v.exp_err));
    check_frame(name, v, pre_n);
    $display("txn %0d %s: %s phy=%0d reg=%0d rdata=0x%04h err=%0b lat=%0d",
             id, name, v.write ? "WR" : "RD", v.phy, v.rg, o_rsp_rdata, o_rsp_err, cyc);
  endtask

  task automatic run_txn(input int id, input string name, input vec_t v, input bit no_pre);
    int pre_n = no_pre ? 0 : PRE;
    start_req(v, no_pre);
    wait_accept(name);
    i_req_valid = 1'b0;
    check({name, "_bit0_oe"}, 32'(mdio_oe), 32'd1);
    check({name, "_bit0_o"}, 32'(mdio_o), 32'(pre_n > 0 ? 1 : 0));
    finish_txn(id, name, v, pre_n);
    @(posedge clk);
    #1;
    check({name, "_pulse_len"}, 32'(o_rsp_valid), 32'd0);
    check({name, "_idle_ready"}, 32'(o_req_ready), 32'd1);
    check({name, "_idle_line"}, {29'd0, mdc, mdio_oe, mdio_o}, 32'b001);
    check({name, "_rdata_held"}, 32'(o_rsp_rdata), 32'(v.exp_rdata));
  endtask

  vec_t vecs[6];
  vec_t va, vb, vr;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd1,  5'd0,  16'h1140, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 5'd1,  5'd2,  16'h0000, 1'b1, 16'h796D, 16'h796D, 1'b0};
    vecs[2] = '{1'b0, 5'd3,  5'd2,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    vecs[3] = '{1'b1, 5'd31, 5'd31, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 5'd10, 5'd21, 16'hBEEF, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 5'd21, 5'd10, 16'h0000, 1'b1, 16'hA5C3, 16'hA5C3, 1'b0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mdc", 32'(mdc), 32'd0);
    check("rst_mdio_o", 32'(mdio_o), 32'd1);
    check("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rdata", 32'(o_rsp_rdata), 32'd0);
    check("rst_err", 32'(o_rsp_err), 32'd0);
    i_reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_mdc_quiet", {30'd0, mdc, mdio_oe}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_txn(i, $sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Back-to-back: valid held; second request taken the cycle after the pulse.
    va = vecs[3];
    vb = vecs[2];
    start_req(va, 1'b0);
    wait_accept("b2b_a");
    i_req_write = vb.write;
    i_req_phy   = vb.phy;
    i_req_reg   = vb.rg;
    i_req_wdata = vb.wdata;
    finish_txn(6, "b2b_a", va, PRE);
    @(posedge clk);
    #1;
    check("b2b_gap_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_second_accept", {30'd0, o_busy, o_req_ready}, 32'b10);
    i_req_valid = 1'b0;
    phy_on = vb.phy_on;
    finish_txn(7, "b2b_b", vb, PRE);
    @(posedge clk);
    #1;

    // Reset during bit 40 of a write: abort, no response, outputs cleared.
    start_req(vecs[0], 1'b0);
    wait_accept("abort");
    i_req_valid = 1'b0;
    repeat (40 * 2 * D + 2) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_line", {29'd0, mdc, mdio_oe, o_req_ready}, 32'b001);
    check("abort_rdata", 32'(o_rsp_rdata), 32'd0);
    check("abort_err", 32'(o_rsp_err), 32'd0);
    i_reset = 1'b0;
    begin
      int pulses = 0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk);
        #1;
        if (o_rsp_valid) pulses++;
      end
      check("abort_no_rsp", 32'(pulses), 32'd0);
      $display("txn 8 abort: reset at bit 40, pulses after=%0d", pulses);
    end
    vr = vecs[1];
    run_txn(9, "after_abort", vr, 1'b0);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    run_txn(10, "no_pre_wr", vecs[0], 1'b1);
    run_txn(11, "no_pre_rd", vecs[5], 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
